// File: rtl/stack_arb.sv
// stack_arb: round-robin arbiter sharing one push/pop stack between two requesters.
// Define STACK_ARB_WATERMARK_EN to add the hwm (occupancy high-water mark) output.
module stack_arb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       op_pop,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       ack,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    input  logic             flush,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_reset,
    output logic [WIDTH-1:0] stk_in,
    input  logic [WIDTH-1:0] stk_out,
    output logic [DEPTH:0]   depth
`ifdef STACK_ARB_WATERMARK_EN
    ,
    output logic [DEPTH:0]   hwm
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, FLUSH} state_t;

    localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ONE  = {{DEPTH{1'b0}}, 1'b1};

    state_t             state_reg, state_next;
    logic               fav_reg, fav_next;
    logic               win_reg, win_next;
    logic               op_reg, op_next;
    logic               rej_reg, rej_next;
    logic [DEPTH:0]     depth_reg, depth_next;
    logic [1:0]         ack_reg, ack_next;
    logic               err_reg, err_next;
    logic [WIDTH-1:0]   rdata_reg, rdata_next;
    logic               push_reg, push_next;
    logic               pop_reg, pop_next;
    logic               stk_reset_reg, stk_reset_next;
    logic [WIDTH-1:0]   stk_in_reg, stk_in_next;
`ifdef STACK_ARB_WATERMARK_EN
    logic [DEPTH:0]     hwm_reg, hwm_next;
`endif

    logic               win_sel;
    logic               sel_pop;
    logic               sel_rej;
    logic [WIDTH-1:0]   sel_wdata;
    logic [1:0]         win_onehot;

    // The favoured port wins when it requests; otherwise the other port is served.
    assign win_sel   = req[fav_reg] ? fav_reg : ~fav_reg;
    assign sel_pop   = op_pop[win_sel];
    assign sel_wdata = win_sel ? wdata1 : wdata0;
    assign sel_rej   = sel_pop ? (depth_reg == '0) : (depth_reg == FULL);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            assign win_onehot[gi] = (win_reg == 1'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            fav_reg       <= 1'b0;
            win_reg       <= 1'b0;
            op_reg        <= 1'b0;
            rej_reg       <= 1'b0;
            depth_reg     <= '0;
            ack_reg       <= '0;
            err_reg       <= 1'b0;
            rdata_reg     <= '0;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            stk_reset_reg <= 1'b1;
            stk_in_reg    <= '0;
`ifdef STACK_ARB_WATERMARK_EN
            hwm_reg       <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            fav_reg       <= fav_next;
            win_reg       <= win_next;
            op_reg        <= op_next;
            rej_reg       <= rej_next;
            depth_reg     <= depth_next;
            ack_reg       <= ack_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            push_reg      <= push_next;
            pop_reg       <= pop_next;
            stk_reset_reg <= stk_reset_next;
            stk_in_reg    <= stk_in_next;
`ifdef STACK_ARB_WATERMARK_EN
            hwm_reg       <= hwm_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        fav_next       = fav_reg;
        win_next       = win_reg;
        op_next        = op_reg;
        rej_next       = rej_reg;
        depth_next     = depth_reg;
        rdata_next     = rdata_reg;
        ack_next       = '0;
        err_next       = 1'b0;
        push_next      = 1'b0;
        pop_next       = 1'b0;
        stk_reset_next = 1'b0;
        stk_in_next    = '0;
`ifdef STACK_ARB_WATERMARK_EN
        hwm_next       = hwm_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (flush) begin
                    stk_reset_next = 1'b1;
                    state_next     = FLUSH;
                end else if (|req) begin
                    // Strobes are registered here so they appear in the ISSUE cycle.
                    win_next   = win_sel;
                    op_next    = sel_pop;
                    rej_next   = sel_rej;
                    push_next  = !sel_pop && !sel_rej;
                    pop_next   = sel_pop && !sel_rej;
                    if (!sel_pop && !sel_rej)
                        stk_in_next = sel_wdata;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!rej_reg) begin
                    if (op_reg) begin
                        depth_next = depth_reg - ONE;
                        // The stack shows its top entry on stk_out until this pop edge.
                        rdata_next = stk_out;
                    end else begin
                        depth_next = depth_reg + ONE;
`ifdef STACK_ARB_WATERMARK_EN
                        if (depth_reg + ONE > hwm_reg)
                            hwm_next = depth_reg + ONE;
`endif
                    end
                end
                ack_next   = win_onehot;
                err_next   = rej_reg;
                state_next = RESP;
            end
            RESP: begin
                fav_next   = ~win_reg;
                state_next = IDLE;
            end
            FLUSH: begin
                depth_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ack       = ack_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign stk_push  = push_reg;
    assign stk_pop   = pop_reg;
    assign stk_reset = stk_reset_reg;
    assign stk_in    = stk_in_reg;
    assign depth     = depth_reg;
`ifdef STACK_ARB_WATERMARK_EN
    assign hwm       = hwm_reg;
`endif

endmodule

// File: tb/tb_stack_arb.sv
// Bench for stack_arb: transaction-level model with a per-cycle compare plus directed checks.
// Exercises hwm as well when STACK_ARB_WATERMARK_EN is defined.
`timescale 1ns/1ps
module tb_stack_arb;
    localparam int WIDTH = 16;
    localparam int DEPTH = 3;
    localparam int CAP   = 8;
    localparam int NCYC  = 4096;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req = '0;
    logic [1:0]       op_pop = '0;
    logic [WIDTH-1:0] wdata0 = '0;
    logic [WIDTH-1:0] wdata1 = '0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] stk_out = '0;
    logic [1:0]       ack;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic             stk_push, stk_pop, stk_reset;
    logic [WIDTH-1:0] stk_in;
    logic [DEPTH:0]   depth;
`ifdef STACK_ARB_WATERMARK_EN
    logic [DEPTH:0]   hwm;
`endif

    stack_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .req(req), .op_pop(op_pop),
        .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
        .flush(flush), .stk_push(stk_push), .stk_pop(stk_pop), .stk_reset(stk_reset),
        .stk_in(stk_in), .stk_out(stk_out), .depth(depth)
`ifdef STACK_ARB_WATERMARK_EN
        , .hwm(hwm)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit valid = 1'b0;

    // Expected per-cycle values, filled in by the model ahead of time.
    bit             e_push [NCYC];
    bit             e_pop  [NCYC];
    bit             e_rst  [NCYC];
    bit             e_err  [NCYC];
    bit [1:0]       e_ack  [NCYC];
    bit [WIDTH-1:0] e_in   [NCYC];
    bit [WIDTH-1:0] er     [NCYC];
    int             ed     [NCYC];
    int             eh     [NCYC];
    bit             er_set [NCYC];
    bit             ed_set [NCYC];
    bit             eh_set [NCYC];

    int             m_depth;
    int             m_hwm;
    bit [WIDTH-1:0] m_stack [$];
    bit [WIDTH-1:0] dev [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stack instance stand-in: top entry presented on stk_out as a register.
    initial begin : stack_dev
        forever begin
            @(posedge clk);
            if (stk_reset)
                dev.delete();
            else if (stk_push)
                dev.push_back(stk_in);
            else if (stk_pop && dev.size() > 0)
                void'(dev.pop_back());
            stk_out <= (dev.size() > 0) ? dev[$] : '0;
        end
    end

    // Model: the block is idle from free_cyc; a request sampled in idle cycle k gives
    // its strobe in k+1 and its ack in k+2; a flush gives stk_reset in k+1.
    initial begin : model
        int c;
        int free_cyc;
        bit fav;
        bit win;
        bit is_pop;
        bit rej;
        free_cyc = 0;
        fav = 1'b0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            c = cyc;
            if (c >= NCYC - 2) begin
                $display("FAIL cycle_budget: cycle %0d exceeds %0d", c, NCYC - 2);
                $fatal(1, "cycle budget");
            end
            if (reset) begin
                valid = 1'b1;
                free_cyc = c;
                fav = 1'b0;
                m_depth = 0;
                m_hwm = 0;
                m_stack.delete();
                e_rst[c] = 1'b1;
                e_ack[c] = '0;
                e_err[c] = 1'b0;
                ed[c] = 0;
                er[c] = '0;
                eh[c] = 0;
            end else begin
                if (!ed_set[c]) ed[c] = ed[c-1];
                if (!er_set[c]) er[c] = er[c-1];
                if (!eh_set[c]) eh[c] = eh[c-1];
                if (valid && (c - 1 >= free_cyc)) begin
                    if (flush) begin
                        e_rst[c] = 1'b1;
                        m_stack.delete();
                        m_depth = 0;
                        ed[c+1] = 0;
                        ed_set[c+1] = 1'b1;
                        free_cyc = c + 1;
                    end else if (req != 2'b00) begin
                        win = req[fav] ? fav : !fav;
                        is_pop = op_pop[win];
                        rej = is_pop ? (m_depth == 0) : (m_depth == CAP);
                        if (!rej && is_pop) begin
                            e_pop[c] = 1'b1;
                            er[c+1] = m_stack.pop_back();
                            er_set[c+1] = 1'b1;
                            m_depth--;
                        end else if (!rej) begin
                            e_push[c] = 1'b1;
                            e_in[c] = win ? wdata1 : wdata0;
                            m_stack.push_back(e_in[c]);
                            m_depth++;
                            if (m_depth > m_hwm) m_hwm = m_depth;
                        end
                        ed[c+1] = m_depth;
                        ed_set[c+1] = 1'b1;
                        eh[c+1] = m_hwm;
                        eh_set[c+1] = 1'b1;
                        e_ack[c+1] = win ? 2'b10 : 2'b01;
                        e_err[c+1] = rej;
                        fav = !win;
                        free_cyc = c + 2;
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (valid) begin
                chk("stk_push", stk_push, e_push[cyc]);
                chk("stk_pop", stk_pop, e_pop[cyc]);
                chk("stk_reset", stk_reset, e_rst[cyc]);
                chk("ack", ack, e_ack[cyc]);
                chk("depth", depth, ed[cyc]);
                chk("rdata", rdata, er[cyc]);
                if (e_push[cyc]) chk("stk_in", stk_in, e_in[cyc]);
                if (e_ack[cyc] != 2'b00) chk("err", err, e_err[cyc]);
`ifdef STACK_ARB_WATERMARK_EN
                chk("hwm", hwm, eh[cyc]);
`endif
                if (ack != 2'b00)
                    $display("txn cycle=%0d ack=%b err=%0b rdata=%h depth=%0d",
                             cyc, ack, err, rdata, depth);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        req = '0;
        flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One transaction from idle; returns at the negedge of its ack cycle.
    task automatic txn(input int port, input bit is_pop, input logic [WIDTH-1:0] data,
                       output logic e, output logic [WIDTH-1:0] rd);
        int s;
        int lat;
        tick();
        if (port == 0) wdata0 = data; else wdata1 = data;
        op_pop[port] = is_pop;
        req[port] = 1'b1;
        s = cyc;
        lat = -1;
        e = 1'b0;
        rd = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack[port]) begin
                lat = cyc - s;
                e = err;
                rd = rdata;
                break;
            end
        end
        req[port] = 1'b0;
        chk("ack_latency", lat, 2);
    endtask

    initial begin : driver
        logic             e;
        logic [WIDTH-1:0] rd;
        int               n;
        int               order [4];
        int               s;
        int               rc;
        int               ac;

        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_stk_reset", stk_reset, 1);
        chk("rst_depth", depth, 0);
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);

        // Two pushes from port 0, popped back from port 1
        txn(0, 1'b0, 16'h1111, e, rd);
        chk("p0_push1_err", e, 0);
        chk("p0_push1_depth", depth, 1);
        txn(0, 1'b0, 16'h2222, e, rd);
        chk("p0_push2_err", e, 0);
        chk("p0_push2_depth", depth, 2);
        txn(1, 1'b1, 16'h0000, e, rd);
        chk("p1_pop1_rdata", rd, 16'h2222);
        txn(1, 1'b1, 16'h0000, e, rd);
        chk("p1_pop2_rdata", rd, 16'h1111);
        chk("pop_depth", depth, 0);

        // Underflow from reset
        reset_dut();
        txn(0, 1'b1, 16'h0000, e, rd);
        chk("underflow_err", e, 1);
        chk("underflow_depth", depth, 0);

        // Fill to capacity, then overflow
        reset_dut();
        for (int i = 0; i < CAP; i++) begin
            txn(1, 1'b0, 16'(16'h0100 + i), e, rd);
            chk("fill_err", e, 0);
        end
        chk("full_depth", depth, 8);
        txn(1, 1'b0, 16'hBEEF, e, rd);
        chk("overflow_err", e, 1);
        chk("overflow_depth", depth, 8);
        txn(0, 1'b1, 16'h0000, e, rd);
        chk("after_full_rdata", rd, 16'h0107);
        chk("after_full_depth", depth, 7);

        // Both ports requesting continuously
        reset_dut();
        tick();
        op_pop = 2'b00;
        wdata0 = 16'hA0A0;
        wdata1 = 16'hB1B1;
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                order[n] = ack[1] ? 1 : 0;
                n++;
                if (n == 4) req = 2'b00;
            end
        end
        req = 2'b00;
        chk("arb_count", n, 4);
        for (int k = 0; k < 4; k++) chk("arb_order", order[k], k % 2);
        chk("arb_depth", depth, 4);

        // Flush and request together: flush first, then the request
        reset_dut();
        for (int i = 0; i < 5; i++) txn(0, 1'b0, 16'(16'h0500 + i), e, rd);
        chk("pre_flush_depth", depth, 5);
        tick();
        flush = 1'b1;
        op_pop[0] = 1'b0;
        wdata0 = 16'h5555;
        req[0] = 1'b1;
        s = cyc;
        tick();
        flush = 1'b0;
        rc = -1;
        ac = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (stk_reset && rc < 0) rc = cyc;
            if (ack[0]) begin
                ac = cyc;
                break;
            end
        end
        req = 2'b00;
        chk("flush_reset_cycle", rc - s, 1);
        chk("flush_to_ack", ac - rc, 3);
        chk("flush_then_push_depth", depth, 1);

        // Reset during ISSUE aborts the transaction
        tick();
        op_pop[0] = 1'b0;
        wdata0 = 16'h7777;
        req[0] = 1'b1;
        tick();
        reset = 1'b1;
        req = 2'b00;
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack != 2'b00) n++;
        end
        chk("abort_no_ack", n, 0);
        chk("abort_depth", depth, 0);

`ifdef STACK_ARB_WATERMARK_EN
        // High-water mark survives flush
        reset_dut();
        for (int i = 0; i < 3; i++) txn(0, 1'b0, 16'(16'h0300 + i), e, rd);
        txn(1, 1'b1, 16'h0000, e, rd);
        txn(1, 1'b1, 16'h0000, e, rd);
        txn(0, 1'b0, 16'h0399, e, rd);
        chk("hwm_after_ops", hwm, 3);
        chk("hwm_ops_depth", depth, 2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("hwm_after_flush", hwm, 3);
        chk("flush_depth", depth, 0);
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
